// File: rtl/counter_trio.sv
// counter_trio: three WIDTH-bit up-counters with load, wrap pulses and snapshot.
// Define COUNTER_TRIO_CASCADE_EN to chain the counters into one ripple counter.
module counter_trio #(
  parameter int WIDTH = 4,
  parameter int INIT1 = 5,
  parameter int INIT2 = 7,
  parameter int INIT3 = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load_valid,
  input  logic [1:0]       load_sel,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count1,
  output logic [WIDTH-1:0] count2,
  output logic [WIDTH-1:0] count3,
  output logic             tc1,
  output logic             tc2,
  output logic             tc3,
  input  logic             snap_req,
  output logic             snap_valid,
  input  logic             snap_ack,
  output logic [WIDTH-1:0] snap1,
  output logic [WIDTH-1:0] snap2,
  output logic [WIDTH-1:0] snap3
);

  localparam logic [WIDTH-1:0] MAX = '1;

  logic ld1, ld2, ld3;
  logic step1, step2, step3;
  logic carry1, carry2, carry3;
  logic snap_take;

  // Decode which counters the load strobe targets.
  always_comb begin
    ld1 = load_valid & ((load_sel == 2'd0) | (load_sel == 2'd3));
    ld2 = load_valid & ((load_sel == 2'd1) | (load_sel == 2'd3));
    ld3 = load_valid & ((load_sel == 2'd2) | (load_sel == 2'd3));
  end

  // Step sources and carries; a loaded counter neither wraps nor carries.
  always_comb begin
    step1  = en;
    carry1 = step1 & ~ld1 & (count1 == MAX);
`ifdef COUNTER_TRIO_CASCADE_EN
    step2  = carry1;
`else
    step2  = en;
`endif
    carry2 = step2 & ~ld2 & (count2 == MAX);
`ifdef COUNTER_TRIO_CASCADE_EN
    step3  = carry2;
`else
    step3  = en;
`endif
    carry3 = step3 & ~ld3 & (count3 == MAX);
  end

  // Counter registers and their wrap pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      count1 <= WIDTH'(INIT1);
      count2 <= WIDTH'(INIT2);
      count3 <= WIDTH'(INIT3);
      tc1    <= 1'b0;
      tc2    <= 1'b0;
      tc3    <= 1'b0;
    end else begin
      if (ld1)        count1 <= load_data;
      else if (step1) count1 <= count1 + 1'b1;
      if (ld2)        count2 <= load_data;
      else if (step2) count2 <= count2 + 1'b1;
      if (ld3)        count3 <= load_data;
      else if (step3) count3 <= count3 + 1'b1;
      tc1 <= carry1;
      tc2 <= carry2;
      tc3 <= carry3;
    end
  end

  // A new capture is allowed when the slot is empty or being freed.
  always_comb begin
    snap_take = snap_req & (~snap_valid | snap_ack);
  end

  // Snapshot slot: capture pre-update counts, hold until acknowledged.
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_valid <= 1'b0;
      snap1      <= '0;
      snap2      <= '0;
      snap3      <= '0;
    end else if (snap_take) begin
      snap_valid <= 1'b1;
      snap1      <= count1;
      snap2      <= count2;
      snap3      <= count3;
    end else if (snap_ack) begin
      snap_valid <= 1'b0;
    end
  end

endmodule

// File: doc/counter_trio.md
# counter_trio

Bank of three WIDTH-bit up-counters with per-counter parallel load, terminal-count pulses and a snapshot handshake. It is the design-side counterpart of the counter stimulus benches: it holds count1/count2/count3 as real registers updated on one edge, and offers a consistent three-value snapshot to an observer. It sits beside the training counters as the DUT those benches drive.

## Interface
- WIDTH, 4: bit width of each counter.
- INIT1, 5: reset value of count1.
- INIT2, 7: reset value of count2.
- INIT3, 11: reset value of count3.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset. It is named `rst` because the `n` suffix denotes active-low.
- en  in  1  count enable.
- load_valid  in  1  load strobe, one-cycle qualifier.
- load_sel  in  2  load target: 0=count1, 1=count2, 2=count3, 3=all three.
- load_data  in  WIDTH  load value.
- count1, count2, count3  out  WIDTH  counter registers.
- tc1, tc2, tc3  out  1  wrap pulses.
- snap_req  in  1  snapshot request.
- snap_valid  out  1  snapshot held.
- snap_ack  in  1  snapshot consumed.
- snap1, snap2, snap3  out  WIDTH  snapshot values.

## Operation
- Reset state: count1=INIT1, count2=INIT2, count3=INIT3; tc1..3=0; snap_valid=0; snap1..3=0.
- Step condition per counter (see Configuration): when the step condition is true and the counter is not being loaded, count <= count+1 modulo 2^WIDTH.
- Load: when load_valid=1, each selected counter takes load_data on the edge. Load has priority over stepping for the selected counter. Unselected counters step normally in the same cycle.
- Wrap: tcN=1 for exactly the cycle in which countN shows 0 as a result of a step from 2^WIDTH-1. A load of 0 does not assert tcN. tcN is 0 in all other cycles.
- Carry: carryN is combinational and equals 1 when counter N steps this cycle and countN = 2^WIDTH-1. It is suppressed if counter N is loaded this cycle.
- Snapshot handshake:
  - A request is accepted when snap_req=1 and (snap_valid=0 or snap_ack=1).
  - On acceptance, snap1..3 <= count1..3 as sampled at that edge (pre-update values), and snap_valid <= 1.
  - snap_ack=1 with no accepted request: snap_valid <= 0, and snap1..3 hold.
  - snap_req while snap_valid=1 and snap_ack=0: ignored; the snapshot is unchanged.
  - snap_req and snap_ack in the same cycle: the new capture replaces the old one and snap_valid stays 1.
  - snap1..3 never change while snap_valid=1 and snap_ack=0.
- All registers update on the same rising edge; there are no combinational paths from inputs to count, tc or snap outputs.

## Timing
- Count and load latency: 1 cycle (value visible after the edge that samples en/load_valid).
- tcN coincides with the 0 value, 1 cycle after the edge where countN = max and it steps.
- Cascaded carry ripples in zero added cycles: with the counter values 15/15/15 and en=1, all three counters become 0 on one edge and tc1..3 all pulse together.
- Snapshot: snap_valid rises 1 cycle after the accepted snap_req; the captured values are the counts before that edge's update.
- rst has priority over every input. Asserting it mid-count, mid-load or with a snapshot pending restores the reset state on that edge and drops snap_valid without an ack.

## Configuration
- COUNTER_TRIO_CASCADE_EN defined:
  - count1 steps on en.
  - count2 steps on carry1.
  - count3 steps on carry2.
  - The three counters form one 3·WIDTH-bit ripple counter.
- Not defined: all three counters step independently on en; carries are unused.
- Load, snapshot and tc behaviour are identical in both builds.

## Test plan
- Reset: hold rst for 3 cycles, then release -> count1/2/3 = 5/7/11, tc=0, snap_valid=0; values unchanged while en=0.
- Simultaneous load: load_valid=1, load_sel=3, load_data=9, en=1 -> next cycle 9/9/9, no tc; load_sel=1, load_data=2 with count1=15, en=1 -> count2=2, count1=0, tc1=1.
- Cascade (macro defined): load 15/15/14, pulse en for 1 cycle -> 0/0/15, tc1=tc2=1, tc3=0. Independent build, same stimulus -> 0/0/15, tc1=tc2=1.
- Snapshot ordering: counts 5/7/11, en=1, snap_req=1 -> snap 5/7/11, counts 6/7/11 (cascade) or 6/8/12 (independent); snap_req again without ack -> snap unchanged; snap_ack=1 -> snap_valid=0.
- Req+ack same cycle: with snap_valid=1, assert both -> snap_valid stays 1 with new values.
- Reset mid-operation: rst=1 together with load_valid=1 and snap_req=1 -> reset values only, snap_valid=0.
